// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator execute-phase sequencer.
package calc_pkg;

  localparam int unsigned DATA_W              = 8;
  localparam int unsigned OP_W                = 3;
  localparam int unsigned DEF_MAX_RESULT      = 99;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 1024;

  // State encoding
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_CONVERT    = 3'd1;
  localparam logic [2:0] ST_ALU_SETTLE = 3'd2;
  localparam logic [2:0] ST_DD_RUN     = 3'd3;
  localparam logic [2:0] ST_DONE       = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE       = ST_IDLE,
    S_CONVERT    = ST_CONVERT,
    S_ALU_SETTLE = ST_ALU_SETTLE,
    S_DD_RUN     = ST_DD_RUN,
    S_DONE       = ST_DONE
  } seq_state_e;

  // ALU operation codes
  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_MUL = 3'b011,
    OP_DIV = 3'b100
  } alu_op_e;

  // Display value that blanks both seven-segment digits
  localparam logic [DATA_W-1:0] BLANK_BCD = 8'hFF;

  // Operand pair captured from the two BCD-to-binary converters
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } operands_t;

endpackage

// File: rtl/calc_exec_sequencer_if.sv
// Handshake/bus bundle between the execute sequencer and its converters, ALU and display.
interface calc_exec_sequencer_if;
  import calc_pkg::*;

  logic              i_Start;
  logic              i_Abort;
  logic [OP_W-1:0]   i_Op_Code;
  logic              o_Bbc_En;
  logic              i_Bbc1_DV;
  logic              i_Bbc2_DV;
  logic [DATA_W-1:0] i_Bbc1_Num;
  logic [DATA_W-1:0] i_Bbc2_Num;
  logic [DATA_W-1:0] o_Operand_A;
  logic [DATA_W-1:0] o_Operand_B;
  logic [OP_W-1:0]   o_Alu_Op;
  logic [DATA_W-1:0] i_Alu_Out;
  logic              o_Dd_En;
  logic [DATA_W-1:0] o_Dd_Bin;
  logic              i_Dd_DV;
  logic [DATA_W-1:0] i_Dd_Bcd;
  logic [DATA_W-1:0] o_Result_Bcd;
  logic              o_Result_Valid;
  logic              o_Busy;
  logic              o_Overflow;
  logic              o_Error;

  // Sequencer side
  modport master (
    input  i_Start, i_Abort, i_Op_Code,
    input  i_Bbc1_DV, i_Bbc2_DV, i_Bbc1_Num, i_Bbc2_Num,
    input  i_Alu_Out, i_Dd_DV, i_Dd_Bcd,
    output o_Bbc_En, o_Operand_A, o_Operand_B, o_Alu_Op,
    output o_Dd_En, o_Dd_Bin, o_Result_Bcd, o_Result_Valid,
    output o_Busy, o_Overflow, o_Error
  );

  // Keypad FSM / converter / ALU / display side
  modport slave (
    output i_Start, i_Abort, i_Op_Code,
    output i_Bbc1_DV, i_Bbc2_DV, i_Bbc1_Num, i_Bbc2_Num,
    output i_Alu_Out, i_Dd_DV, i_Dd_Bcd,
    input  o_Bbc_En, o_Operand_A, o_Operand_B, o_Alu_Op,
    input  o_Dd_En, o_Dd_Bin, o_Result_Bcd, o_Result_Valid,
    input  o_Busy, o_Overflow, o_Error
  );

endinterface

// File: rtl/calc_seq_dv_collector.sv
// Sticky capture of the two converter results; both_seen_c rises in the cycle the last one lands.
module calc_seq_dv_collector
  import calc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              dv_a,
  input  logic              dv_b,
  input  logic [DATA_W-1:0] num_a,
  input  logic [DATA_W-1:0] num_b,
  output operands_t         ops,
  output logic              both_seen_c
);

  logic seen_a;
  logic seen_b;

  // Seen bits clear on request; operand latches hold until overwritten by a new valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_a <= 1'b0;
      seen_b <= 1'b0;
      ops    <= '0;
    end else if (clr) begin
      seen_a <= 1'b0;
      seen_b <= 1'b0;
    end else if (en) begin
      if (dv_a) begin
        seen_a <= 1'b1;
        ops.a  <= num_a;
      end
      if (dv_b) begin
        seen_b <= 1'b1;
        ops.b  <= num_b;
      end
    end
  end

  // Count a valid arriving this cycle as already seen
  always_comb begin
    both_seen_c = en && (seen_a || dv_a) && (seen_b || dv_b);
  end

endmodule

// File: rtl/calc_exec_sequencer.sv
// Execute-phase sequencer: converters -> ALU -> double-dabble -> display value.
// Optional watchdog on the wait states is enabled by defining CALC_SEQ_TIMEOUT_EN.
module calc_exec_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned MAX_RESULT     = DEF_MAX_RESULT,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  calc_exec_sequencer_if.master bus
);

  seq_state_e        state_q, state_d;
  operands_t         ops_q;
  logic              both_seen_c;
  logic              coll_en_c;
  logic              coll_clr_c;
  logic              timeout_c;

  logic              bbc_en_q,   bbc_en_d;
  logic              dd_en_q,    dd_en_d;
  logic              valid_q,    valid_d;
  logic              busy_q,     busy_d;
  logic              overflow_q, overflow_d;
  logic              error_q,    error_d;
  logic [DATA_W-1:0] result_q,   result_d;
  logic [DATA_W-1:0] dd_bin_q,   dd_bin_d;
  logic [OP_W-1:0]   alu_op_q,   alu_op_d;

  // Operands are only captured while converters are enabled; seen bits drop otherwise
  always_comb begin
    coll_en_c  = (state_q == S_CONVERT) && !bus.i_Abort;
    coll_clr_c = (state_q != S_CONVERT) || bus.i_Abort;
  end

  calc_seq_dv_collector u_dv_collector (
    .clk         (i_Clk),
    .rst_n       (i_Rst_L),
    .clr         (coll_clr_c),
    .en          (coll_en_c),
    .dv_a        (bus.i_Bbc1_DV),
    .dv_b        (bus.i_Bbc2_DV),
    .num_a       (bus.i_Bbc1_Num),
    .num_b       (bus.i_Bbc2_Num),
    .ops         (ops_q),
    .both_seen_c (both_seen_c)
  );

`ifdef CALC_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WD_W-1:0] wd_q, wd_d;
  logic            waiting_c;

  // Watchdog expiry in either wait state
  always_comb begin
    waiting_c = (state_q == S_CONVERT) || (state_q == S_DD_RUN);
    timeout_c = waiting_c && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  end

  // Counter restarts on every state change and counts cycles spent waiting
  always_comb begin
    wd_d = '0;
    if (waiting_c && (state_d == state_q)) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  // Watchdog counter register
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic unused_timeout_cfg;

  // Without the watchdog the sequencer waits indefinitely
  always_comb begin
    timeout_c          = 1'b0;
    unused_timeout_cfg = ^TIMEOUT_CYCLES;
  end
`endif

  // State register
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-output logic; abort overrides every transition
  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q;
    error_d    = error_q;
    result_d   = result_q;
    dd_bin_d   = dd_bin_q;
    alu_op_d   = alu_op_q;

    if (bus.i_Abort) begin
      state_d    = S_IDLE;
      result_d   = BLANK_BCD;
      overflow_d = 1'b0;
      error_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.i_Start) begin
            alu_op_d   = bus.i_Op_Code;
            overflow_d = 1'b0;
            error_d    = 1'b0;
            state_d    = S_CONVERT;
          end
        end
        S_CONVERT: begin
          if (both_seen_c) begin
            state_d = S_ALU_SETTLE;
          end else if (timeout_c) begin
            error_d  = 1'b1;
            result_d = BLANK_BCD;
            state_d  = S_DONE;
          end
        end
        S_ALU_SETTLE: begin
          dd_bin_d = bus.i_Alu_Out;
          if (bus.i_Alu_Out > DATA_W'(MAX_RESULT)) begin
            overflow_d = 1'b1;
            result_d   = BLANK_BCD;
            state_d    = S_DONE;
          end else begin
            state_d = S_DD_RUN;
          end
        end
        S_DD_RUN: begin
          if (bus.i_Dd_DV) begin
            result_d = bus.i_Dd_Bcd;
            state_d  = S_DONE;
          end else if (timeout_c) begin
            error_d  = 1'b1;
            result_d = BLANK_BCD;
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    bbc_en_d = (state_d == S_CONVERT);
    dd_en_d  = (state_d == S_DD_RUN);
    valid_d  = (state_d == S_DONE);
    busy_d   = (state_d != S_IDLE);
  end

  // Output registers, all decoded from the next state so they align with it
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      bbc_en_q   <= 1'b0;
      dd_en_q    <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
      result_q   <= BLANK_BCD;
      dd_bin_q   <= '0;
      alu_op_q   <= '0;
    end else begin
      bbc_en_q   <= bbc_en_d;
      dd_en_q    <= dd_en_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      error_q    <= error_d;
      result_q   <= result_d;
      dd_bin_q   <= dd_bin_d;
      alu_op_q   <= alu_op_d;
    end
  end

  assign bus.o_Bbc_En       = bbc_en_q;
  assign bus.o_Operand_A    = ops_q.a;
  assign bus.o_Operand_B    = ops_q.b;
  assign bus.o_Alu_Op       = alu_op_q;
  assign bus.o_Dd_En        = dd_en_q;
  assign bus.o_Dd_Bin       = dd_bin_q;
  assign bus.o_Result_Bcd   = result_q;
  assign bus.o_Result_Valid = valid_q;
  assign bus.o_Busy         = busy_q;
  assign bus.o_Overflow     = overflow_q;
  assign bus.o_Error        = error_q;

endmodule
